mul_unit_cu: RTL and testbench

//  Control unit sitting directly upstream of the multiplier datapath: accepts a

---
 rtl/mul_cu_pkg.sv | 27 ++
 rtl/mul_unit_cu.sv | 143 ++++++++++++++
 tb/tb_mul_unit_cu.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_cu_pkg.sv
// Shared types for the multiplier control unit: FSM states and the datapath strobe bundle.
package mul_cu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    ITER  = 3'd3,
    FINAL = 3'd4,
    RESP  = 3'd5
  } state_t;

  typedef struct packed {
    logic csa_clear;
    logic multiplicand_en;
    logic notMultiplicand_en;
    logic sumMux_sel;
    logic sum_en;
    logic carry_en;
    logic leftAddMux_sel;
    logic count_en;
    logic prod_en;
  } dp_ctrl_t;

  localparam dp_ctrl_t DP_CTRL_IDLE = '0;

endpackage

// File: rtl/mul_unit_cu.sv
// Multiplier control unit: request handshake, operand capture, datapath strobe
// sequencing with an ITER watchdog, and the downstream response handshake.
module mul_unit_cu
  import mul_cu_pkg::*;
#(
  parameter int PARALLELISM = 32,
  parameter int ITER_MAX    = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_usigned,
  input  logic [PARALLELISM-1:0] req_multiplier,
  input  logic [PARALLELISM-1:0] req_multiplicand,
  input  logic                   flush,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_err,
  output logic                   dp_usigned,
  output logic [PARALLELISM-1:0] dp_multiplier,
  output logic [PARALLELISM-1:0] dp_multiplicand,
  output logic                   dp_csa_clear,
  output logic                   dp_multiplicand_en,
  output logic                   dp_notMultiplicand_en,
  output logic                   dp_sumMux_sel,
  output logic                   dp_sum_en,
  output logic                   dp_carry_en,
  output logic                   dp_leftAddMux_sel,
  output logic                   dp_count_en,
  output logic                   dp_prod_en,
  input  logic                   dp_tc
);

  localparam int WDW = $clog2(ITER_MAX + 1);

  state_t                 state_q, state_d;
  logic                   err_q, err_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   us_q;
  logic [PARALLELISM-1:0] a_q, b_q;
  dp_ctrl_t               ctrl;
  logic                   accept;

  // Flush blocks acceptance so an aborted cycle never captures a new request.
  assign req_ready = !flush && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wd_d    = wd_q;
    ctrl    = DP_CTRL_IDLE;
    case (state_q)
      IDLE: if (accept) begin
        state_d = CLEAR;
        err_d   = 1'b0;
      end
      CLEAR: begin
        ctrl.csa_clear = 1'b1;
        state_d        = LOAD;
      end
      LOAD: begin
        ctrl.multiplicand_en    = 1'b1;
        ctrl.notMultiplicand_en = 1'b1;
        ctrl.sum_en             = 1'b1;
        wd_d                    = '0;
        state_d                 = ITER;
      end
      ITER: begin
        ctrl.sumMux_sel     = 1'b1;
        ctrl.sum_en         = 1'b1;
        ctrl.carry_en       = 1'b1;
        ctrl.leftAddMux_sel = 1'b1;
        ctrl.count_en       = 1'b1;
        wd_d                = wd_q + 1'b1;
        // Terminal count wins over a watchdog expiry landing in the same cycle.
        if (dp_tc) begin
          state_d = FINAL;
        end else if (wd_q == WDW'(ITER_MAX - 1)) begin
          state_d = FINAL;
          err_d   = 1'b1;
        end
      end
      FINAL: begin
        ctrl.leftAddMux_sel = 1'b1;
        ctrl.prod_en        = 1'b1;
        state_d             = RESP;
      end
      RESP: if (resp_ready) begin
        if (accept) begin
          state_d = CLEAR;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d        = IDLE;
      err_d          = 1'b0;
      ctrl           = DP_CTRL_IDLE;
      ctrl.csa_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      wd_q    <= '0;
      us_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      if (accept) begin
        us_q <= req_usigned;
        a_q  <= req_multiplier;
        b_q  <= req_multiplicand;
      end
    end
  end

  assign resp_valid            = (state_q == RESP);
  assign resp_err              = resp_valid && err_q;
  assign dp_usigned            = us_q;
  assign dp_multiplier         = a_q;
  assign dp_multiplicand       = b_q;
  assign dp_csa_clear          = ctrl.csa_clear;
  assign dp_multiplicand_en    = ctrl.multiplicand_en;
  assign dp_notMultiplicand_en = ctrl.notMultiplicand_en;
  assign dp_sumMux_sel         = ctrl.sumMux_sel;
  assign dp_sum_en             = ctrl.sum_en;
  assign dp_carry_en           = ctrl.carry_en;
  assign dp_leftAddMux_sel     = ctrl.leftAddMux_sel;
  assign dp_count_en           = ctrl.count_en;
  assign dp_prod_en            = ctrl.prod_en;

endmodule

// File: tb/tb_mul_unit_cu.sv
// Scoreboard bench for mul_unit_cu with a behavioural datapath stand-in
// (iteration counter -> dp_tc, product register loaded on prod_en).
module tb_mul_unit_cu;

  localparam int P  = 32;
  localparam int IM = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0, req_ready, req_usigned = 1'b0;
  logic [P-1:0] req_multiplier = '0, req_multiplicand = '0;
  logic         flush = 1'b0, resp_valid, resp_ready = 1'b1, resp_err;
  logic         dp_usigned;
  logic [P-1:0] dp_multiplier, dp_multiplicand;
  logic         dp_csa_clear, dp_multiplicand_en, dp_notMultiplicand_en, dp_sumMux_sel;
  logic         dp_sum_en, dp_carry_en, dp_leftAddMux_sel, dp_count_en, dp_prod_en, dp_tc;

  mul_unit_cu #(.PARALLELISM(P), .ITER_MAX(IM)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_usigned(req_usigned),
    .req_multiplier(req_multiplier), .req_multiplicand(req_multiplicand),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .dp_usigned(dp_usigned), .dp_multiplier(dp_multiplier), .dp_multiplicand(dp_multiplicand),
    .dp_csa_clear(dp_csa_clear), .dp_multiplicand_en(dp_multiplicand_en),
    .dp_notMultiplicand_en(dp_notMultiplicand_en), .dp_sumMux_sel(dp_sumMux_sel),
    .dp_sum_en(dp_sum_en), .dp_carry_en(dp_carry_en), .dp_leftAddMux_sel(dp_leftAddMux_sel),
    .dp_count_en(dp_count_en), .dp_prod_en(dp_prod_en), .dp_tc(dp_tc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Datapath stand-in: 32 counted iterations, product computed on prod_en.
  logic        tc_en = 1'b1;
  logic [5:0]  dp_cnt;
  logic [63:0] prod;
  assign dp_tc = tc_en && (dp_cnt == 6'd31);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_cnt <= '0;
      prod   <= '0;
    end else begin
      if (dp_csa_clear)     dp_cnt <= '0;
      else if (dp_count_en) dp_cnt <= dp_cnt + 6'd1;
      if (dp_prod_en)
        prod <= dp_usigned ? ({32'b0, dp_multiplier} * {32'b0, dp_multiplicand})
                           : ($signed({{32{dp_multiplier[31]}}, dp_multiplier}) *
                              $signed({{32{dp_multiplicand[31]}}, dp_multiplicand}));
    end
  end

  typedef struct {
    logic [63:0] prod;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;
  exp_t sbq[$];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  logic        seen = 1'b0, held = 1'b0, hold_err;
  logic [63:0] hold_prod;
  int          first_cyc;
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (resp_valid && held) begin
        chk("hold_prod", prod, hold_prod);
        chk("hold_err", {63'b0, resp_err}, {63'b0, hold_err});
      end
      if (resp_valid && resp_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got response %h with empty scoreboard", prod);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("product", prod, e.prod);
          chk("resp_err", {63'b0, resp_err}, {63'b0, e.err});
          chk("latency", 64'(first_cyc - e.issue), 64'(e.lat));
        end
        seen = 1'b0;
        held = 1'b0;
      end else if (resp_valid) begin
        held = 1'b1;
        hold_prod = prod;
        hold_err = resp_err;
      end else begin
        held = 1'b0;
      end
    end
  end

  function automatic logic [10:0] obs();
    return {req_ready, resp_valid, dp_csa_clear, dp_multiplicand_en, dp_notMultiplicand_en,
            dp_sumMux_sel, dp_sum_en, dp_carry_en, dp_leftAddMux_sel, dp_count_en, dp_prod_en};
  endfunction

  // Drives one request until accepted; scrambles the operand bus afterwards.
  task automatic issue(input bit us, input logic [P-1:0] a, input logic [P-1:0] b,
                       input logic [63:0] p, input bit err, input int lat, input bit push);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_usigned = us; req_multiplier = a; req_multiplicand = b;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL req_timeout: req_ready never rose");
        req_valid = 1'b0;
        return;
      end
    end
    if (push) sbq.push_back('{p, err, lat, cyc});
    @(posedge clk); #1;
    req_valid = 1'b0; req_usigned = ~us;
    req_multiplier = 32'hDEAD_BEEF; req_multiplicand = 32'h1234_5678;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 || resp_valid) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL drain_timeout: %0d responses outstanding", sbq.size());
        return;
      end
    end
  endtask

  initial begin
    logic [10:0] ex;
    int vcount;
    repeat (2) @(negedge clk);
    chk("rst_obs", {53'b0, obs()}, {53'b0, 11'b100_0000_0000});
    chk("rst_err", {63'b0, resp_err}, 64'd0);
    chk("rst_ops", {31'b0, dp_usigned, dp_multiplier}, 64'd0);
    chk("rst_mcand", {32'b0, dp_multiplicand}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_obs", {53'b0, obs()}, {53'b0, 11'b100_0000_0000});

    // Signed 7 x -3 with a per-cycle strobe trace.
    issue(1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 36, 1'b1);
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1)       ex = 11'b00_100000000;
      else if (k == 2)  ex = 11'b00_011010000;
      else if (k <= 34) ex = 11'b00_000111110;
      else if (k == 35) ex = 11'b00_000000101;
      else              ex = 11'b11_000000000;
      chk($sformatf("trace_c%0d", k), {53'b0, obs()}, {53'b0, ex});
    end
    drain();

    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 36, 1'b1);
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0, 36, 1'b1);
    issue(1'b1, 32'd3, 32'd5, 64'd15, 1'b0, 36, 1'b1);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 36, 1'b1);
    drain();

    // Response stalled 5 cycles, then released together with the next request.
    resp_ready = 1'b0;
    issue(1'b1, 32'd6, 32'd7, 64'd42, 1'b0, 36, 1'b1);
    begin
      int n = 0;
      while (!resp_valid && n < 100) begin @(negedge clk); n++; end
      chk("stall_valid", {63'b0, resp_valid}, 64'd1);
    end
    repeat (5) @(negedge clk);
    chk("stall_ready", {63'b0, req_ready}, 64'd0);
    @(posedge clk); #1;
    resp_ready = 1'b1; req_valid = 1'b1; req_usigned = 1'b1;
    req_multiplier = 32'd100; req_multiplicand = 32'd200;
    @(negedge clk);
    chk("b2b_ready", {63'b0, req_ready}, 64'd1);
    sbq.push_back('{64'd20000, 1'b0, 36, cyc});
    @(posedge clk); #1 req_valid = 1'b0; req_multiplier = '0;
    @(negedge clk);
    chk("b2b_clear", {63'b0, dp_csa_clear}, 64'd1);
    chk("b2b_opnd", {32'b0, dp_multiplier}, 64'd100);
    drain();

    // Flush during ITER with a competing request.
    issue(1'b1, 32'd5, 32'd5, 64'd25, 1'b0, 36, 1'b0);
    repeat (6) @(posedge clk);
    #1 flush = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    chk("flush_obs", {53'b0, obs()}, {53'b0, 11'b00_100000000});
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("post_flush", {53'b0, obs()}, {53'b0, 11'b100_0000_0000});
    vcount = 0;
    repeat (50) begin @(negedge clk); if (resp_valid) vcount++; end
    chk("flush_no_resp", 64'(vcount), 64'd0);

    // Watchdog: no terminal count, forced finish with error.
    tc_en = 1'b0;
    issue(1'b1, 32'd2, 32'd3, 64'd6, 1'b1, 3 + IM + 1, 1'b1);
    drain();
    tc_en = 1'b1;
    issue(1'b1, 32'd9, 32'd9, 64'd81, 1'b0, 36, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
